act_fetch_skew: RTL and testbench

Activation fetch and skew stage between the on-chip activation scratchpad and the systolic array's input buffer. It takes the per-lane read addresses and valid bits produced by the input auto-tiling address generator. It performs a multi-port read of a locally held activation memory, zero-pads invalid lanes, and applies the diagonal (lane-i delayed by i cycles) skew required by the array. A host-side byte write port fills the memory between tiles.

---
 rtl/act_fetch_skew.sv | 77 +++++++
 tb/tb_act_fetch_skew.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/act_fetch_skew.sv
// act_fetch_skew: activation memory with per-lane multi-port read, zero padding and diagonal skew
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   wr_en/wr_addr/wr_data  host byte write into the activation memory
//   rd_req              read beat strobe (one element per lane)
//   rd_valid            per-lane address valid; invalid lanes emit zero padding
//   rd_addrs            packed per-lane read addresses
//   skew_clear          synchronous flush of all pipeline and delay state
//   out_act             packed per-lane output data
//   out_lane_valid      per-lane beat tag
// Macro ACT_FETCH_SKEW_EN: when defined, lane i is delayed i extra cycles; otherwise all lanes align.
module act_fetch_skew #(
  parameter int DATASIZE   = 8,
  parameter int LANES      = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [DATASIZE-1:0]         wr_data,
  input  logic                        rd_req,
  input  logic [LANES-1:0]            rd_valid,
  input  logic [LANES*ADDR_WIDTH-1:0] rd_addrs,
  input  logic                        skew_clear,
  output logic [LANES*DATASIZE-1:0]   out_act,
  output logic [LANES-1:0]            out_lane_valid
);
  logic [DATASIZE-1:0] r_mem [2**ADDR_WIDTH];
  // Memory is never reset; nonblocking write gives read-before-write on same-address collisions.
  always_ff @(posedge clk)
    if (wr_en) r_mem[wr_addr] <= wr_data;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATASIZE-1:0] r_s1_data;
    logic                r_s1_tag;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_s1_data <= '0;
        r_s1_tag  <= 1'b0;
      end else if (skew_clear) begin
        r_s1_data <= '0;
        r_s1_tag  <= 1'b0;
      end else begin
        r_s1_data <= (rd_req && rd_valid[i]) ? r_mem[rd_addrs[i*ADDR_WIDTH +: ADDR_WIDTH]] : '0;
        r_s1_tag  <= rd_req;
      end
`ifdef ACT_FETCH_SKEW_EN
    if (i == 0) begin : g_direct
      assign out_act[i*DATASIZE +: DATASIZE] = r_s1_data;
      assign out_lane_valid[i]               = r_s1_tag;
    end else begin : g_dly
      // Lane i carries i extra registers so that beat elements enter the array diagonally.
      logic [DATASIZE-1:0] r_dly_data [i];
      logic                r_dly_tag  [i];
      always_ff @(posedge clk or posedge rst)
        if (rst || skew_clear) begin
          for (int k = 0; k < i; k++) begin
            r_dly_data[k] <= '0;
            r_dly_tag[k]  <= 1'b0;
          end
        end else begin
          r_dly_data[0] <= r_s1_data;
          r_dly_tag[0]  <= r_s1_tag;
          for (int k = 1; k < i; k++) begin
            r_dly_data[k] <= r_dly_data[k-1];
            r_dly_tag[k]  <= r_dly_tag[k-1];
          end
        end
      assign out_act[i*DATASIZE +: DATASIZE] = r_dly_data[i-1];
      assign out_lane_valid[i]               = r_dly_tag[i-1];
    end
`else
    assign out_act[i*DATASIZE +: DATASIZE] = r_s1_data;
    assign out_lane_valid[i]               = r_s1_tag;
`endif
  end
endmodule

// File: tb/tb_act_fetch_skew.sv
// tb_act_fetch_skew: scoreboard bench for act_fetch_skew with a behavioural memory/timeline model
module tb_act_fetch_skew;
  localparam int DS = 8;
  localparam int LN = 8;
  localparam int AW = 10;
`ifdef ACT_FETCH_SKEW_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DS-1:0] wr_data = '0;
  logic rd_req = 1'b0;
  logic [LN-1:0] rd_valid = '0;
  logic [LN*AW-1:0] rd_addrs = '0;
  logic skew_clear = 1'b0;
  logic [LN*DS-1:0] out_act;
  logic [LN-1:0] out_lane_valid;
  act_fetch_skew #(.DATASIZE(DS), .LANES(LN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_addrs(rd_addrs), .skew_clear(skew_clear),
    .out_act(out_act), .out_lane_valid(out_lane_valid)
  );
  always #5 clk = ~clk;
  typedef struct {int due; int lane; logic [DS-1:0] d;} ent_t;
  ent_t sb[$];
  logic [DS-1:0] tmem [2**AW];
  int edge_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  logic [LN*DS-1:0] exp_d;
  logic [LN-1:0] exp_v;
  always @(posedge clk) edge_cnt++;
  // Monitor: after edge E, the lanes whose scheduled slot is E must show their element; all others idle.
  always @(negedge clk) if (mon_en) begin
    exp_d = '0;
    exp_v = '0;
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].due == edge_cnt) begin
        exp_v[sb[k].lane] = 1'b1;
        exp_d[sb[k].lane*DS +: DS] = sb[k].d;
        sb.delete(k);
      end
    n_cmp++;
    if (out_lane_valid !== exp_v) begin
      n_bad++;
      $display("FAIL valid edge=%0d got=%h exp=%h", edge_cnt, out_lane_valid, exp_v);
    end
    n_cmp++;
    if (out_act !== exp_d) begin
      n_bad++;
      $display("FAIL data edge=%0d got=%h exp=%h", edge_cnt, out_act, exp_d);
    end
  end
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DS-1:0] wd,
                      input logic req, input logic [LN-1:0] vld, input logic [LN*AW-1:0] ad,
                      input logic clr);
    int e;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_req = req; rd_valid = vld; rd_addrs = ad; skew_clear = clr;
    e = edge_cnt + 1;
    if (clr) begin
      for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].due >= e) sb.delete(k);
    end else if (req) begin
      for (int i = 0; i < LN; i++)
        sb.push_back('{e + i*SK, i, vld[i] ? tmem[ad[i*AW +: AW]] : '0});
    end
    if (we) tmem[wa] = wd;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask
  function automatic logic [LN*AW-1:0] same_addr(input logic [AW-1:0] a);
    logic [LN*AW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*AW +: AW] = a;
    return r;
  endfunction
  logic [LN*AW-1:0] ad_id;
  logic [LN*AW-1:0] ad_r;
  initial begin
    for (int i = 0; i < LN; i++) ad_id[i*AW +: AW] = AW'(i);
    #1;
    n_cmp++;
    if (out_act !== '0 || out_lane_valid !== '0) begin
      n_bad++;
      $display("FAIL reset_state got=%h/%h exp=0/0", out_act, out_lane_valid);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < LN; i++) step(1'b1, AW'(i), DS'(8'h10 + i), 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 8'hFF, ad_id, 1'b0);
    idle(LN + 1);
    step(1'b0, '0, '0, 1'b1, 8'hF7, ad_id, 1'b0);
    idle(LN + 1);
    step(1'b1, AW'(9), 8'hAA, 1'b0, '0, '0, 1'b0);
    step(1'b1, AW'(9), 8'hBB, 1'b1, 8'hFF, same_addr(AW'(9)), 1'b0);
    step(1'b0, '0, '0, 1'b1, 8'hFF, same_addr(AW'(9)), 1'b0);
    idle(LN + 1);
    for (int k = 0; k < 8; k++) step(1'b0, '0, '0, 1'b1, 8'hFF, same_addr(AW'(k)), k == 4);
    idle(LN + 1);
    // Clear together with a write: the write must still land.
    step(1'b1, AW'(5), 8'h5C, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 8'hFF, same_addr(AW'(5)), 1'b0);
    idle(LN + 1);
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1, 8'hFF, ad_id, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_act !== '0 || out_lane_valid !== '0) begin
      n_bad++;
      $display("FAIL async_reset got=%h/%h exp=0/0", out_act, out_lane_valid);
    end
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    step(1'b0, '0, '0, 1'b1, 8'hFF, ad_id, 1'b0);
    idle(LN + 1);
    for (int a = 0; a < 32; a++) step(1'b1, AW'(a), DS'($urandom), 1'b0, '0, '0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < LN; i++) ad_r[i*AW +: AW] = AW'($urandom_range(0, 31));
      step($urandom_range(0, 2) == 0, AW'($urandom_range(0, 31)), DS'($urandom),
           $urandom_range(0, 3) != 0, LN'($urandom), ad_r, $urandom_range(0, 19) == 0);
    end
    idle(LN + 2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
